// File: rtl/rr_report_pkg.sv
// rr_report_pkg: shared constants, types and checksum helper for the RR UART reporter.
package rr_report_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int FRAME_BYTES = 8;
    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} rr_state_e;
    typedef struct packed {
        logic [23:0] loc;
        logic [23:0] rr;
    } rr_event_t;
    function automatic logic [7:0] rr_checksum(input rr_event_t e);
        return e.rr[23:16] ^ e.rr[15:8] ^ e.rr[7:0] ^ e.loc[23:16] ^ e.loc[15:8] ^ e.loc[7:0];
    endfunction
endpackage

// File: rtl/rr_event_fifo.sv
// rr_event_fifo: synchronous event FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module rr_event_fifo
    import rr_report_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      i_clk,
    input  logic      i_nrst,
    input  logic      i_push,
    input  logic      i_pop,
    input  rr_event_t i_data,
    output rr_event_t o_data,
    output logic      o_full,
    output logic      o_empty
);
    localparam int AW = $clog2(DEPTH);
    rr_event_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0] count;
    logic do_push, do_pop;
    assign o_full  = count == DEPTH[AW:0];
    assign o_empty = count == '0;
    assign do_pop  = i_pop && !o_empty;
    assign do_push = i_push && (!o_full || do_pop);
    assign o_data  = mem[rd_ptr];
    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr] <= i_data;
    end
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/rr_uart_reporter.sv
// rr_uart_reporter: buffers RR events and sends each as an 8-byte 8N1 UART frame
// (A5, rr[23:0], loc[23:0], XOR checksum), MSB byte first.
module rr_uart_reporter
    import rr_report_pkg::*;
#(
    parameter int CTR_WIDTH  = 22,
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_nrst,
    input  logic                 i_ce,
    input  logic [CTR_WIDTH-1:0] i_rr_period,
    input  logic                 i_rr_period_updated,
    input  logic [CTR_WIDTH-1:0] i_r_peak_location,
    output logic                 o_tx,
    output logic                 o_busy,
    output logic                 o_fifo_overflow,
    output logic [15:0]          o_frame_count
);
    if (CTR_WIDTH > 24 || CTR_WIDTH < 1) begin : g_bad_width
        $error("CTR_WIDTH must be in 1..24");
    end
    if (CLK_DIV < 2) begin : g_bad_div
        $error("CLK_DIV must be >= 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end

    localparam int BW = $clog2(CLK_DIV);

    rr_state_e state;
    rr_event_t fifo_out, frame_q;
    logic [7:0] csum_q, shreg;
    logic [BW-1:0] baud;
    logic [2:0] bit_idx, byte_idx, nxt_idx;
    logic [63:0] word;
    logic full, empty, pop, bit_end;

    assign pop     = i_ce && state == IDLE && !empty;
    assign o_busy  = state != IDLE || !empty;
    assign bit_end = baud == BW'(CLK_DIV - 1);
    assign nxt_idx = byte_idx + 3'd1;
    assign word    = {SYNC_BYTE, frame_q.rr, frame_q.loc, csum_q};

    rr_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk  (i_clk),
        .i_nrst (i_nrst),
        .i_push (i_rr_period_updated),
        .i_pop  (pop),
        .i_data ('{loc: 24'(i_r_peak_location), rr: 24'(i_rr_period)}),
        .o_data (fifo_out),
        .o_full (full),
        .o_empty(empty)
    );

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state           <= IDLE;
            o_tx            <= 1'b1;
            o_fifo_overflow <= 1'b0;
            o_frame_count   <= '0;
            frame_q         <= '0;
            csum_q          <= '0;
            shreg           <= '0;
            baud            <= '0;
            bit_idx         <= '0;
            byte_idx        <= '0;
        end else begin
            if (i_rr_period_updated && full && !pop) o_fifo_overflow <= 1'b1;
            if (i_ce) begin
                case (state)
                    IDLE: if (!empty) begin
                        frame_q <= fifo_out;
                        csum_q  <= rr_checksum(fifo_out);
                        state   <= LOAD;
                    end
                    LOAD: begin
                        byte_idx <= '0;
                        shreg    <= SYNC_BYTE;
                        o_tx     <= 1'b0;
                        state    <= START;
                    end
                    START: if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        o_tx    <= shreg[0];
                        state   <= DATA;
                    end else baud <= baud + BW'(1);
                    DATA: if (bit_end) begin
                        baud    <= '0;
                        shreg   <= shreg >> 1;
                        bit_idx <= bit_idx + 3'd1;
                        o_tx    <= bit_idx == 3'd7 ? 1'b1 : shreg[1];
                        state   <= bit_idx == 3'd7 ? STOP : DATA;
                    end else baud <= baud + BW'(1);
                    STOP: if (bit_end) begin
                        baud <= '0;
                        if (byte_idx == 3'(FRAME_BYTES - 1)) begin
                            o_frame_count <= o_frame_count + 16'd1;
                            state         <= IDLE;
                        end else begin
                            // next byte starts immediately: no idle gap between bytes of a frame
                            byte_idx <= nxt_idx;
                            shreg    <= word[{~nxt_idx, 3'b000} +: 8];
                            o_tx     <= 1'b0;
                            state    <= START;
                        end
                    end else baud <= baud + BW'(1);
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: doc/rr_uart_reporter.md
Name: rr_uart_reporter

Overview:
- Consumer end of the QRS detection core's RR result interface.
- Captures each `rr_period_updated` event (RR period plus R-peak location) into a small FIFO.
- Serialises each captured event as a fixed 8-byte frame on a UART 8N1 transmit line for host logging.
- Sits beside the detection core at top level, driven by the same clock and counter domain.

Parameters:
- CTR_WIDTH, 22, width of RR period and R-peak location; must be ≤ 24 (elaboration error otherwise).
- CLK_DIV, 868, clock cycles per UART bit; must be ≥ 2.
- FIFO_DEPTH, 4, number of buffered events; power of two, ≥ 2.

Ports:
- i_clk  in  1  system clock
- i_nrst  in  1  asynchronous active-low reset
- i_ce  in  1  clock enable for the transmit path (baud counter, FSM, FIFO pop)
- i_rr_period  in  CTR_WIDTH  RR period from the detector
- i_rr_period_updated  in  1  single-cycle strobe; i_rr_period and i_r_peak_location are valid this cycle
- i_r_peak_location  in  CTR_WIDTH  counter value at the R peak
- o_tx  out  1  UART serial output, idle high
- o_busy  out  1  high while a frame is in flight or the FIFO is non-empty
- o_fifo_overflow  out  1  sticky: an event was dropped
- o_frame_count  out  16  frames fully transmitted, wraps modulo 2^16

Behaviour:
- Reset (asynchronous, takes effect immediately): o_tx=1, o_busy=0, o_fifo_overflow=0, o_frame_count=0, FIFO empty, FSM=IDLE, baud and bit counters 0. Reset mid-frame aborts the frame; o_tx returns high at once.
- Capture:
  - Independent of i_ce.
  - On i_rr_period_updated=1, push {i_r_peak_location, i_rr_period} if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise drop the event and set o_fifo_overflow=1. It clears only on reset.
- Frame layout, MSB byte first:
  - Byte 0: 0xA5 sync.
  - Bytes 1-3: rr_period zero-extended to 24 bits.
  - Bytes 4-6: r_peak_location zero-extended to 24 bits.
  - Byte 7: XOR of bytes 1-6.
- Byte encoding: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly CLK_DIV i_ce-qualified cycles.
- FSM, advancing only when i_ce=1:
  - IDLE: if FIFO non-empty, pop into a 48-bit frame register and compute the checksum → LOAD.
  - LOAD: byte index=0, load shift register → START.
  - START: o_tx=0 for one bit time → DATA.
  - DATA: 8 bit times, shift right → STOP.
  - STOP: o_tx=1 for one bit time. If byte index<7: increment, → START. Else: o_frame_count+=1, → IDLE.
  - Back-to-back frames: IDLE re-pops on the next enabled cycle; the gap is 2 cycles of idle-high between frames.
- Latency: strobe at cycle N with FIFO empty and FSM idle, i_ce=1 → pop at N+1, LOAD at N+2, o_tx falls at N+3.
- Frame duration: 80·CLK_DIV cycles plus 2 cycles overhead.
- i_ce=0: o_tx holds its current level and all counters freeze. Capture continues.
- o_tx is registered (no combinational glitches).
- o_busy = (state != IDLE) | fifo_not_empty.
- Simultaneous push and pop on a full FIFO: both succeed, no overflow.
- Pointers wrap modulo FIFO_DEPTH. Fill count has log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Package rr_report_pkg:
  - SYNC_BYTE = 8'hA5, FRAME_BYTES = 8.
  - Typedef of the FSM state enum {IDLE, LOAD, START, DATA, STOP}.
  - Typedef rr_event_t: packed struct {loc, rr}, each 24 bits.
- One sub-module, rr_event_fifo: synchronous FIFO with full/empty, push/pop, async active-low reset.
- Byte serialiser and frame sequencing stay in the top module.

Test Plan:
- CLK_DIV=4, FIFO_DEPTH=4 for all cases.
- Single event: rr=0x000123, loc=0x0ABCDE → o_tx bytes A5 00 01 23 0A BC DE 4A; o_tx falls 3 cycles after the strobe; 322 cycles to idle; o_frame_count=1.
- CTR_WIDTH=22, rr=0x3FFFFF, loc=0 → bytes A5 3F FF FF 00 00 00 3F; each bit exactly 4 cycles wide.
- Overflow: 6 strobes spaced 10 cycles apart with distinct rr=1..6 → frames rr=1..5 sent in order, event 6 dropped, o_fifo_overflow=1, o_frame_count=5.
- Full FIFO plus pop-cycle strobe: FIFO full, strobe coincides with the IDLE pop → accepted, o_fifo_overflow stays 0.
- i_ce toggling 1/0 alternately during a frame → bit widths stretch to 8 cycles; byte values unchanged; strobe during i_ce=0 still captured.
- Assert i_nrst low mid-byte 3 → o_tx=1 immediately, o_busy=0, FIFO empty, counters 0; a new strobe afterwards produces a clean full frame.
